fp_result_packer: RTL and testbench

Parametrised output stage of the floating-point MAC datapath, replacing the fixed single-precision result register. Takes the unrounded sign/exponent/significand from the normaliser and rounds it under one of four modes. Handles overflow, underflow and special operands, then packs the IEEE-style word with status flags. Results are buffered in a small FIFO behind a valid/ready handshake so the MAC core can be back-pressured by its consumer.

---
 rtl/fp_pkg.sv | 50 +++++
 rtl/fp_result_fifo.sv | 61 ++++++
 rtl/fp_result_packer.sv | 168 ++++++++++++++++
 tb/tb_fp_result_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding-mode encodings, status flag bit
// positions and the rounding increment decision.
package fp_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_OVERFLOW  = 3;
    localparam int FLG_UNDERFLOW = 2;
    localparam int FLG_INEXACT   = 1;
    localparam int FLG_ZERO      = 0;
    localparam int FLG_W         = 5;

    // Decides whether the kept significand is bumped by one ulp.
    function automatic logic round_increment(
        input rnd_mode_e mode,
        input logic      sign,
        input logic      lsb,
        input logic      guard,
        input logic      round,
        input logic      sticky
    );
        logic lost;
        lost = guard | round | sticky;
        case (mode)
            RND_RNE: return guard & (round | sticky | lsb);
            RND_RTZ: return 1'b0;
            RND_RUP: return ~sign & lost;
            RND_RDN: return sign & lost;
            default: return 1'b0;
        endcase
    endfunction

    // Overflow saturates to infinity or to the largest finite value.
    function automatic logic overflow_to_inf(input rnd_mode_e mode, input logic sign);
        case (mode)
            RND_RNE: return 1'b1;
            RND_RTZ: return 1'b0;
            RND_RUP: return ~sign;
            RND_RDN: return sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Parametrised synchronous FIFO with occupancy count; any DEPTH, pointers wrap
// modulo DEPTH. Pushes when full and pops when empty are ignored.
module fp_result_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: storage is deliberately not reset; count gates visibility, so stale
    // entries can never reach the output and the array stays plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all state updates use non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fp_result_packer.sv
// MAC output stage: rounds the normaliser result, classifies and packs it into
// an IEEE-style word with status flags, and buffers it behind valid/ready.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic signed [EXP_W+1:0] in_exponent,
    input  logic [MAN_W+3:0]       in_significand,
    input  logic                   in_nan,
    input  logic                   in_inf,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [FLG_W-1:0]       out_flags
);

    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic signed [EXP_W+2:0] EXP_OVF  = signed'((EXP_W+3)'((1 << EXP_W) - 1));
    localparam logic signed [EXP_W+2:0] EXP_ZERO = '0;

    // ---------------- stage 1: round ----------------
    logic                    accept;
    logic                    in_hidden;
    logic [MAN_W-1:0]        in_frac;
    logic                    in_g, in_r, in_s;
    rnd_mode_e               in_mode;
    logic                    rnd_inc;
    logic [MAN_W:0]          frac_sum;
    logic                    hidden_carry;
    logic signed [EXP_W+2:0] rnd_exp;

    assign in_hidden = in_significand[MAN_W+3];
    assign in_frac   = in_significand[MAN_W+2:3];
    assign in_g      = in_significand[2];
    assign in_r      = in_significand[1];
    assign in_s      = in_significand[0];
    assign in_mode   = rnd_mode_e'(rnd_mode);

    assign rnd_inc  = round_increment(in_mode, in_sign, in_frac[0], in_g, in_r, in_s);
    assign frac_sum = {1'b0, in_frac} + {{MAN_W{1'b0}}, rnd_inc};
    // Fraction overflow only moves the exponent when the hidden bit was set;
    // otherwise it just promotes the value to a set hidden bit.
    assign hidden_carry = in_hidden & frac_sum[MAN_W];
    assign rnd_exp = signed'({in_exponent[EXP_W+1], in_exponent})
                   + signed'({{(EXP_W+2){1'b0}}, hidden_carry});

    logic                    s1_valid;
    logic                    s1_sign;
    logic signed [EXP_W+2:0] s1_exp;
    logic [MAN_W-1:0]        s1_frac;
    logic                    s1_nan;
    logic                    s1_inf;
    logic                    s1_zero;
    logic                    s1_inexact;
    rnd_mode_e               s1_mode;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_frac    <= '0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_inexact <= 1'b0;
            s1_mode    <= RND_RNE;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign    <= in_sign;
                s1_exp     <= rnd_exp;
                s1_frac    <= frac_sum[MAN_W-1:0];
                s1_nan     <= in_nan;
                s1_inf     <= in_inf;
                s1_zero    <= (in_significand == '0);
                s1_inexact <= in_g | in_r | in_s;
                s1_mode    <= in_mode;
            end
        end
    end

    // ---------------- stage 2: classify and pack ----------------
    logic             res_sign;
    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_frac;
    logic [FLG_W-1:0] res_flags;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        res_sign  = s1_sign;
        res_exp   = s1_exp[EXP_W-1:0];
        res_frac  = s1_frac;
        res_flags = '0;
        res_flags[FLG_INEXACT] = s1_inexact;

        if (s1_nan) begin
            res_sign  = 1'b0;
            res_exp   = '1;
            res_frac  = {1'b1, {(MAN_W-1){1'b0}}};
            res_flags = '0;
            res_flags[FLG_INVALID] = 1'b1;
        end else if (s1_inf) begin
            res_exp   = '1;
            res_frac  = '0;
            res_flags = '0;
        end else if (s1_zero) begin
            res_exp   = '0;
            res_frac  = '0;
            res_flags = '0;
            res_flags[FLG_ZERO] = 1'b1;
        end else if (s1_exp >= EXP_OVF) begin
            res_flags[FLG_OVERFLOW] = 1'b1;
            res_flags[FLG_INEXACT]  = 1'b1;
            if (overflow_to_inf(s1_mode, s1_sign)) begin
                res_exp  = '1;
                res_frac = '0;
            end else begin
                res_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
                res_frac = '1;
            end
        end else if (s1_exp <= EXP_ZERO) begin
            res_exp   = '0;
            res_frac  = '0;
            res_flags[FLG_UNDERFLOW] = 1'b1;
            res_flags[FLG_ZERO]      = 1'b1;
            res_flags[FLG_INEXACT]   = 1'b1;
        end
    end

    // ---------------- output buffer and credit ----------------
    logic [CNT_W-1:0]        fifo_count;
    logic [FLG_W+WORD_W-1:0] head_data;

    // Stage 2 writes the FIFO directly, so s1 plus the FIFO is the whole
    // occupancy; credit depends on registers only, never on out_ready.
    assign in_ready = (int'(fifo_count) + int'(s1_valid)) < DEPTH;
    assign accept   = in_valid & in_ready;

    fp_result_fifo #(
        .WIDTH (FLG_W + WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .push       (s1_valid),
        .push_data  ({res_flags, res_sign, res_exp, res_frac}),
        .pop        (out_ready),
        .head_data  (head_data),
        .head_valid (out_valid),
        .count      (fifo_count)
    );

    assign out_flags = head_data[FLG_W+WORD_W-1:WORD_W];
    assign out_data  = head_data[WORD_W-1:0];

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer: directed vectors push expected words,
// a negedge monitor pops and compares every handshake at the output.
module tb_fp_result_packer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exponent = '0;
    logic [26:0] in_significand = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic [1:0]  rnd_mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_flags;

    always #5 clock = ~clock;

    fp_result_packer #(.EXP_W(8), .MAN_W(23), .DEPTH(4)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exponent    (in_exponent),
        .in_significand (in_significand),
        .in_nan         (in_nan),
        .in_inf         (in_inf),
        .rnd_mode       (rnd_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_flags      (out_flags)
    );

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] sig;
        logic        nan;
        logic        inf;
        logic [1:0]  mode;
        logic [31:0] data;
        logic [4:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails = 0;
    int   emitted = 0;

    localparam logic [26:0] SIG_ONE   = 27'h4000000; // 1.0, GRS=000
    localparam logic [26:0] SIG_ONES  = 27'h7FFFFFC; // 1.111..1, GRS=100
    localparam logic [26:0] SIG_TIE   = 27'h4000004; // 1.0, GRS=100
    localparam logic [26:0] SIG_STKY  = 27'h4000001; // 1.0, GRS=001
    localparam logic [4:0]  F_NONE = 5'b00000;
    localparam logic [4:0]  F_INX  = 5'b00010;
    localparam logic [4:0]  F_OVF  = 5'b01010;
    localparam logic [4:0]  F_UNF  = 5'b00111;
    localparam logic [4:0]  F_NAN  = 5'b10000;
    localparam logic [4:0]  F_ZERO = 5'b00001;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, need);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [26:0] sig,
                                input logic nan, input logic inf, input logic [1:0] m,
                                input logic [31:0] d, input logic [4:0] f);
        vec_t v;
        v.sign = s; v.exp = e; v.sig = sig; v.nan = nan; v.inf = inf;
        v.mode = m; v.data = d; v.flags = f;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in_sign = v.sign; in_exponent = v.exp; in_significand = v.sig;
        in_nan = v.nan; in_inf = v.inf; rnd_mode = v.mode;
        in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        logic acc;
        int   waited;
        acc = 1'b0;
        waited = 0;
        apply(v);
        while (!acc) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            if (acc) sb_q.push_back({v.data, v.flags});
            #1;
            waited++;
            if (!acc && waited > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            emitted++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", out_data, 32'hxxxxxxxx);
            end else begin
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dir[$];
        vec_t bp[6];
        int   idx;
        int   mark;
        int   bound;
        logic acc;

        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_flags", 32'(out_flags), 32'd0);

        // Latency: accepted in cycle N, head valid in cycle N+2.
        @(posedge clock); #1;
        send(mk(1'b0, 10'd127, SIG_ONE, 1'b0, 1'b0, 2'd0, 32'h3F800000, F_NONE));
        @(negedge clock);
        check("latency_n1_not_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("latency_n2_valid", 32'(out_valid), 32'd1);
        @(posedge clock); #1;

        dir.push_back(mk(1'b0, 10'd127, SIG_ONES, 1'b0, 1'b0, 2'd0, 32'h40000000, F_INX));
        dir.push_back(mk(1'b0, 10'd127, SIG_ONES, 1'b0, 1'b0, 2'd1, 32'h3FFFFFFF, F_INX));
        dir.push_back(mk(1'b0, 10'd255, SIG_ONE,  1'b0, 1'b0, 2'd0, 32'h7F800000, F_OVF));
        dir.push_back(mk(1'b0, 10'd255, SIG_ONE,  1'b0, 1'b0, 2'd1, 32'h7F7FFFFF, F_OVF));
        dir.push_back(mk(1'b1, 10'd255, SIG_ONE,  1'b0, 1'b0, 2'd2, 32'hFF7FFFFF, F_OVF));
        dir.push_back(mk(1'b1, 10'd255, SIG_ONE,  1'b0, 1'b0, 2'd3, 32'hFF800000, F_OVF));
        dir.push_back(mk(1'b0, 10'd255, SIG_ONE,  1'b0, 1'b0, 2'd3, 32'h7F7FFFFF, F_OVF));
        dir.push_back(mk(1'b0, 10'd254, SIG_ONES, 1'b0, 1'b0, 2'd0, 32'h7F800000, F_OVF));
        dir.push_back(mk(1'b1, 10'd0,   SIG_ONE,  1'b0, 1'b0, 2'd0, 32'h80000000, F_UNF));
        dir.push_back(mk(1'b0, 10'h3FD, SIG_ONE,  1'b0, 1'b0, 2'd0, 32'h00000000, F_UNF));
        dir.push_back(mk(1'b1, 10'd127, SIG_ONE,  1'b1, 1'b1, 2'd0, 32'h7FC00000, F_NAN));
        dir.push_back(mk(1'b1, 10'd3,   SIG_ONE,  1'b0, 1'b1, 2'd0, 32'hFF800000, F_NONE));
        dir.push_back(mk(1'b1, 10'd0,   27'd0,    1'b0, 1'b0, 2'd0, 32'h80000000, F_ZERO));
        dir.push_back(mk(1'b0, 10'd127, SIG_TIE,  1'b0, 1'b0, 2'd0, 32'h3F800000, F_INX));
        dir.push_back(mk(1'b0, 10'd127, SIG_STKY, 1'b0, 1'b0, 2'd2, 32'h3F800001, F_INX));
        dir.push_back(mk(1'b1, 10'd127, SIG_STKY, 1'b0, 1'b0, 2'd3, 32'hBF800001, F_INX));
        dir.push_back(mk(1'b0, 10'd127, SIG_STKY, 1'b0, 1'b0, 2'd3, 32'h3F800000, F_INX));
        foreach (dir[i]) send(dir[i]);

        bound = 0;
        while (sb_q.size() != 0 && bound < 100) begin
            @(posedge clock); bound++;
        end
        #1;
        check("directed_drained", 32'(sb_q.size()), 32'd0);

        // Back-pressure: six back-to-back inputs against a stalled consumer.
        for (int i = 0; i < 6; i++)
            bp[i] = mk(1'b0, 10'(127 + i), SIG_ONE, 1'b0, 1'b0, 2'd0,
                       32'h3F800000 + (32'(i) << 23), F_NONE);
        out_ready = 1'b0;
        idx = 0;
        apply(bp[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            if (acc && idx < 6) begin
                sb_q.push_back({bp[idx].data, bp[idx].flags});
                idx++;
            end
            #1;
            if (idx < 6) apply(bp[idx]); else in_valid = 1'b0;
        end
        check("bp_accepted_count", 32'(idx), 32'd4);
        @(negedge clock);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        out_ready = 1'b1;
        bound = 0;
        while (idx < 6 && bound < 50) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            if (acc) begin
                sb_q.push_back({bp[idx].data, bp[idx].flags});
                idx++;
            end
            #1;
            if (idx < 6) apply(bp[idx]); else in_valid = 1'b0;
            bound++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd6);
        bound = 0;
        while (sb_q.size() != 0 && bound < 100) begin
            @(posedge clock); bound++;
        end
        #1;
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Reset with three results in flight.
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        send(bp[2]);
        resetn = 1'b0;
        #1;
        check("reset_async_out_valid", 32'(out_valid), 32'd0);
        sb_q.delete();
        mark = emitted;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("reset_nothing_emitted", 32'(emitted - mark), 32'd0);
        check("reset_out_valid_after", 32'(out_valid), 32'd0);
        check("reset_in_ready_after", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
